// File: rtl/tri_bus_receiver_pkg.sv
// rtl/tri_bus_receiver_pkg.sv - shared defaults and error-kind codes for the tri-state bus receiver
package tri_bus_receiver_pkg;

  localparam int unsigned DEF_NR_OF_BITS    = 32;
  localparam int unsigned DEF_NR_OF_DRIVERS = 4;
  localparam int unsigned DEF_FIFO_DEPTH    = 4;
  localparam logic [7:0]  ERR_COUNT_MAX     = 8'hFF;

  typedef enum logic [1:0] {
    ERR_NONE       = 2'd0,
    ERR_FLOAT      = 2'd1,
    ERR_CONTENTION = 2'd2,
    ERR_OVERFLOW   = 2'd3
  } err_kind_e;

endpackage

// File: rtl/tri_bus_receiver_drv_enable_check.sv
// rtl/tri_bus_receiver_drv_enable_check.sv - popcount classifier of driver enables (one / none / multi)
module drv_enable_check #(
  parameter int NrOfDrivers = 4
) (
  input  logic [NrOfDrivers-1:0] drv_en_i,
  output logic                   is_one_o,
  output logic                   is_none_o,
  output logic                   is_multi_o
);

  localparam int CntW = $clog2(NrOfDrivers + 1);

  logic [CntW-1:0] cnt;

  always_comb begin
    cnt = '0;
    for (int i = 0; i < NrOfDrivers; i++) begin
      cnt = cnt + CntW'(drv_en_i[i]);
    end
  end

  assign is_none_o  = (cnt == '0);
  assign is_one_o   = (cnt == CntW'(1));
  assign is_multi_o = (cnt > CntW'(1));

endmodule

// File: rtl/tri_bus_receiver.sv
// rtl/tri_bus_receiver.sv - bus sampler with enable check, capture FIFO and sticky errors
// Optional saturating error counter: TRI_BUS_ERR_COUNT_EN.
module tri_bus_receiver
  import tri_bus_receiver_pkg::*;
#(
  parameter int NrOfBits    = DEF_NR_OF_BITS,
  parameter int NrOfDrivers = DEF_NR_OF_DRIVERS,
  parameter int FifoDepth   = DEF_FIFO_DEPTH
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic [NrOfBits-1:0]          Bus_data,
  input  logic [NrOfDrivers-1:0]       Bus_drv_en,
  input  logic                         Bus_strobe,
  output logic [NrOfBits-1:0]          Out_data,
  output logic                         Out_valid,
  input  logic                         Out_ready,
  output logic [$clog2(FifoDepth):0]   Fifo_count,
  output logic                         Err_contention,
  output logic                         Err_float,
  output logic                         Err_overflow,
  input  logic                         Err_clear,
  output logic [7:0]                   Err_count
);

  localparam int PtrW = $clog2(FifoDepth);
  localparam int CntW = PtrW + 1;

  logic [NrOfBits-1:0] mem_q [FifoDepth];
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q, rd_next;
  logic [CntW-1:0]     count_q, count_d;
  logic [NrOfBits-1:0] out_data_q, out_data_d;
  logic                err_cont_q, err_float_q, err_ovf_q;

  logic is_one, is_none, is_multi;
  logic push_req, push, pop, full;
  logic cont_ev, float_ev, ovf_ev;

  drv_enable_check #(.NrOfDrivers(NrOfDrivers)) u_check (
    .drv_en_i   (Bus_drv_en),
    .is_one_o   (is_one),
    .is_none_o  (is_none),
    .is_multi_o (is_multi)
  );

  assign push_req = Bus_strobe & is_one;
  assign full     = (count_q == CntW'(FifoDepth));
  assign pop      = (count_q != '0) & Out_ready;
  // A simultaneous pop frees the slot, so a full FIFO still accepts the word.
  assign push     = push_req & (~full | pop);
  assign ovf_ev   = push_req & full & ~pop;
  assign cont_ev  = Bus_strobe & is_multi;
  assign float_ev = Bus_strobe & is_none;
  assign rd_next  = rd_ptr_q + PtrW'(1);
  assign count_d  = count_q + CntW'(push) - CntW'(pop);

  // Registered head: the next head is the following entry, or the incoming word when it lands first.
  always_comb begin
    out_data_d = out_data_q;
    if (pop && (count_q > CntW'(1))) begin
      out_data_d = mem_q[rd_next];
    end else if (push && ((count_q == '0) || pop)) begin
      out_data_d = Bus_data;
    end
  end

  always_ff @(posedge Clock) begin
    if (push && !Reset) begin
      mem_q[wr_ptr_q] <= Bus_data;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_data_q  <= '0;
      err_cont_q  <= 1'b0;
      err_float_q <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_next;
      count_q     <= count_d;
      out_data_q  <= out_data_d;
      err_cont_q  <= (err_cont_q  & ~Err_clear) | cont_ev;
      err_float_q <= (err_float_q & ~Err_clear) | float_ev;
      err_ovf_q   <= (err_ovf_q   & ~Err_clear) | ovf_ev;
    end
  end

  assign Out_data       = out_data_q;
  assign Out_valid      = (count_q != '0);
  assign Fifo_count     = count_q;
  assign Err_contention = err_cont_q;
  assign Err_float      = err_float_q;
  assign Err_overflow   = err_ovf_q;

`ifdef TRI_BUS_ERR_COUNT_EN
  logic [7:0] err_count_q, err_count_d;
  err_kind_e  err_kind;

  always_comb begin
    err_kind = ERR_NONE;
    if (ovf_ev)        err_kind = ERR_OVERFLOW;
    else if (cont_ev)  err_kind = ERR_CONTENTION;
    else if (float_ev) err_kind = ERR_FLOAT;
    err_count_d = err_count_q;
    if ((err_kind != ERR_NONE) && (err_count_q != ERR_COUNT_MAX)) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) err_count_q <= 8'd0;
    else       err_count_q <= err_count_d;
  end

  assign Err_count = err_count_q;
`else
  assign Err_count = 8'd0;
`endif

endmodule

// File: tb/tb_tri_bus_receiver.sv
// tb/tb_tri_bus_receiver.sv - self-checking bench: directed vector table, counter test, random vs queue model
module tb_tri_bus_receiver;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] Bus_data = '0;
  logic [3:0]  Bus_drv_en = '0;
  logic        Bus_strobe = 1'b0;
  logic [31:0] Out_data;
  logic        Out_valid;
  logic        Out_ready = 1'b0;
  logic [2:0]  Fifo_count;
  logic        Err_contention, Err_float, Err_overflow;
  logic        Err_clear = 1'b0;
  logic [7:0]  Err_count;

  tri_bus_receiver dut (
    .Clock(Clock), .Reset(Reset), .Bus_data(Bus_data), .Bus_drv_en(Bus_drv_en),
    .Bus_strobe(Bus_strobe), .Out_data(Out_data), .Out_valid(Out_valid),
    .Out_ready(Out_ready), .Fifo_count(Fifo_count), .Err_contention(Err_contention),
    .Err_float(Err_float), .Err_overflow(Err_overflow), .Err_clear(Err_clear),
    .Err_count(Err_count)
  );

  always #5 Clock = ~Clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic stb, input logic [3:0] en,
                       input logic [31:0] data, input logic rdy, input logic clr);
    Reset = rst; Bus_strobe = stb; Bus_drv_en = en; Bus_data = data;
    Out_ready = rdy; Err_clear = clr;
    @(posedge Clock);
    #1;
  endtask

  typedef struct {
    logic        rst, stb, rdy, clr;
    logic [3:0]  en;
    logic [31:0] data;
    logic        e_valid;
    logic [31:0] e_data;
    int          e_count;
    logic        e_cont, e_flt, e_ovf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic stb, logic [3:0] en, logic [31:0] data,
                              logic rdy, logic clr, logic ev, logic [31:0] ed, int ec,
                              logic c, logic f, logic o);
    vec_t v;
    v.rst = rst; v.stb = stb; v.en = en; v.data = data; v.rdy = rdy; v.clr = clr;
    v.e_valid = ev; v.e_data = ed; v.e_count = ec; v.e_cont = c; v.e_flt = f; v.e_ovf = o;
    return v;
  endfunction

  // Reference model state
  logic [31:0] mq[$];
  logic        m_cont, m_flt, m_ovf;
  int          m_errcnt;

  task automatic model_step(input logic rst, input logic stb, input logic [3:0] en,
                            input logic [31:0] data, input logic rdy, input logic clr);
    int  pc;
    logic good, popped, ev;
    if (rst) begin
      mq.delete(); m_cont = 0; m_flt = 0; m_ovf = 0; m_errcnt = 0;
      return;
    end
    pc     = $countones(en);
    good   = stb && (pc == 1);
    popped = (mq.size() > 0) && rdy;
    ev     = 0;
    if (clr) begin m_cont = 0; m_flt = 0; m_ovf = 0; end
    if (stb && pc >= 2) begin m_cont = 1; ev = 1; end
    if (stb && pc == 0) begin m_flt = 1; ev = 1; end
    if (popped) void'(mq.pop_front());
    if (good) begin
      if (mq.size() < 4) mq.push_back(data);
      else begin m_ovf = 1; ev = 1; end
    end
`ifdef TRI_BUS_ERR_COUNT_EN
    if (ev && m_errcnt < 255) m_errcnt++;
`endif
  endtask

  initial begin
    // Test 1 / 2: first word latency, contention, float, clear, strobe-low ignore, clear vs new error
    tbl.push_back(mk(1,0,4'b0000,32'h0,0,0,        0,32'h0,0,0,0,0));
    tbl.push_back(mk(0,1,4'b0010,32'hDEADBEEF,0,0, 1,32'hDEADBEEF,1,0,0,0));
    tbl.push_back(mk(0,1,4'b0110,32'h11111111,0,0, 1,32'hDEADBEEF,1,1,0,0));
    tbl.push_back(mk(0,1,4'b0000,32'h22222222,0,0, 1,32'hDEADBEEF,1,1,1,0));
    tbl.push_back(mk(0,0,4'b0000,32'h0,0,1,        1,32'hDEADBEEF,1,0,0,0));
    tbl.push_back(mk(0,0,4'b1111,32'h33333333,0,0, 1,32'hDEADBEEF,1,0,0,0));
    tbl.push_back(mk(0,1,4'b0011,32'h44444444,0,1, 1,32'hDEADBEEF,1,1,0,0));
    tbl.push_back(mk(0,0,4'b0000,32'h0,0,1,        1,32'hDEADBEEF,1,0,0,0));
    // Test 3: overflow on fifth word, then drain in order
    tbl.push_back(mk(1,0,4'b0000,32'h0,0,0,        0,32'h0,0,0,0,0));
    tbl.push_back(mk(0,1,4'b0001,32'd1,0,0,        1,32'd1,1,0,0,0));
    tbl.push_back(mk(0,1,4'b0001,32'd2,0,0,        1,32'd1,2,0,0,0));
    tbl.push_back(mk(0,1,4'b0100,32'd3,0,0,        1,32'd1,3,0,0,0));
    tbl.push_back(mk(0,1,4'b1000,32'd4,0,0,        1,32'd1,4,0,0,0));
    tbl.push_back(mk(0,1,4'b0001,32'd5,0,0,        1,32'd1,4,0,0,1));
    tbl.push_back(mk(0,0,4'b0000,32'h0,1,0,        1,32'd2,3,0,0,1));
    tbl.push_back(mk(0,0,4'b0000,32'h0,1,0,        1,32'd3,2,0,0,1));
    tbl.push_back(mk(0,0,4'b0000,32'h0,1,0,        1,32'd4,1,0,0,1));
    tbl.push_back(mk(0,0,4'b0000,32'h0,1,0,        0,32'd4,0,0,0,1));
    // Test 4: full + push + pop in the same cycle
    tbl.push_back(mk(1,0,4'b0000,32'h0,0,0,        0,32'h0,0,0,0,0));
    tbl.push_back(mk(0,1,4'b0001,32'd5,0,0,        1,32'd5,1,0,0,0));
    tbl.push_back(mk(0,1,4'b0001,32'd6,0,0,        1,32'd5,2,0,0,0));
    tbl.push_back(mk(0,1,4'b0001,32'd7,0,0,        1,32'd5,3,0,0,0));
    tbl.push_back(mk(0,1,4'b0001,32'd8,0,0,        1,32'd5,4,0,0,0));
    tbl.push_back(mk(0,1,4'b0010,32'd9,1,0,        1,32'd6,4,0,0,0));
    tbl.push_back(mk(0,0,4'b0000,32'h0,1,0,        1,32'd7,3,0,0,0));
    tbl.push_back(mk(0,0,4'b0000,32'h0,1,0,        1,32'd8,2,0,0,0));
    tbl.push_back(mk(0,0,4'b0000,32'h0,1,0,        1,32'd9,1,0,0,0));
    tbl.push_back(mk(0,0,4'b0000,32'h0,1,0,        0,32'd9,0,0,0,0));
    // Test 5: reset mid-stream with strobe active
    tbl.push_back(mk(0,1,4'b0001,32'hA,0,0,        1,32'hA,1,0,0,0));
    tbl.push_back(mk(0,1,4'b0001,32'hB,0,0,        1,32'hA,2,0,0,0));
    tbl.push_back(mk(0,1,4'b0001,32'hC,0,0,        1,32'hA,3,0,0,0));
    tbl.push_back(mk(0,1,4'b0110,32'hD,0,0,        1,32'hA,3,1,0,0));
    tbl.push_back(mk(1,1,4'b0001,32'hE,1,0,        0,32'h0,0,0,0,0));

    for (int i = 0; i < tbl.size(); i++) begin
      vec_t v;
      v = tbl[i];
      drive(v.rst, v.stb, v.en, v.data, v.rdy, v.clr);
      check($sformatf("vec%0d valid", i), {31'b0, Out_valid}, {31'b0, v.e_valid});
      check($sformatf("vec%0d data", i),  Out_data, v.e_data);
      check($sformatf("vec%0d count", i), {29'b0, Fifo_count}, v.e_count);
      check($sformatf("vec%0d cont", i),  {31'b0, Err_contention}, {31'b0, v.e_cont});
      check($sformatf("vec%0d float", i), {31'b0, Err_float}, {31'b0, v.e_flt});
      check($sformatf("vec%0d ovf", i),   {31'b0, Err_overflow}, {31'b0, v.e_ovf});
    end

    // Test 6: counter saturation under repeated contention
    drive(1,0,4'b0000,32'h0,0,0);
    check("errcnt after reset", {24'b0, Err_count}, 32'd0);
    for (int i = 0; i < 300; i++) drive(0,1,4'b1100,32'h0,0,0);
`ifdef TRI_BUS_ERR_COUNT_EN
    check("errcnt saturated", {24'b0, Err_count}, 32'd255);
`else
    check("errcnt disabled", {24'b0, Err_count}, 32'd0);
`endif
    check("errcnt cont flag", {31'b0, Err_contention}, 32'd1);
    drive(0,0,4'b0000,32'h0,0,1);
`ifdef TRI_BUS_ERR_COUNT_EN
    check("errcnt survives clear", {24'b0, Err_count}, 32'd255);
`else
    check("errcnt survives clear", {24'b0, Err_count}, 32'd0);
`endif

    // Randomized run against the queue model
    drive(1,0,4'b0000,32'h0,0,0);
    model_step(1,0,4'b0000,32'h0,0,0);
    for (int i = 0; i < 600; i++) begin
      logic rst, stb, rdy, clr;
      logic [3:0]  en;
      logic [31:0] data;
      rst  = ($urandom_range(0, 99) == 0);
      stb  = ($urandom_range(0, 9) < 6);
      rdy  = ($urandom_range(0, 9) < 4);
      clr  = ($urandom_range(0, 19) == 0);
      en   = ($urandom_range(0, 3) != 0) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom);
      data = $urandom;
      model_step(rst, stb, en, data, rdy, clr);
      drive(rst, stb, en, data, rdy, clr);
      check($sformatf("rnd%0d count", i), {29'b0, Fifo_count}, mq.size());
      check($sformatf("rnd%0d valid", i), {31'b0, Out_valid}, {31'b0, (mq.size() > 0)});
      if (mq.size() > 0) check($sformatf("rnd%0d data", i), Out_data, mq[0]);
      check($sformatf("rnd%0d flags", i), {29'b0, Err_contention, Err_float, Err_overflow},
            {29'b0, m_cont, m_flt, m_ovf});
      check($sformatf("rnd%0d errcnt", i), {24'b0, Err_count}, m_errcnt);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
